// File: rtl/tinyml_cam_pkg.sv
// rtl/tinyml_cam_pkg.sv - shared encodings for the TinyML camera colour-conversion blocks
package tinyml_cam_pkg;

  typedef enum logic [1:0] {
    GRAY2RGB_REPL = 2'd0,
    GRAY2RGB_HEAT = 2'd1,
    GRAY2RGB_INV  = 2'd2
  } gray2rgb_sel_e;

  // Heatmap segments, indexed by the two gray MSBs (cold to hot).
  localparam logic [1:0] HEAT_SEG_BLUE_CYAN    = 2'd0;
  localparam logic [1:0] HEAT_SEG_CYAN_GREEN   = 2'd1;
  localparam logic [1:0] HEAT_SEG_GREEN_YELLOW = 2'd2;
  localparam logic [1:0] HEAT_SEG_YELLOW_RED   = 2'd3;

  // Encoding 3 is unused by software and behaves as plain replication.
  function automatic gray2rgb_sel_e gray2rgb_decode(input logic [1:0] mode);
    gray2rgb_sel_e sel;
    case (mode)
      2'd1:    sel = GRAY2RGB_HEAT;
      2'd2:    sel = GRAY2RGB_INV;
      default: sel = GRAY2RGB_REPL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gray2rgb_1PPC.sv
// rtl/gray2rgb_1PPC.sv - combinational gray-to-RGB mapping for one pixel lane
module gray2rgb_1PPC
  import tinyml_cam_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] gray_i,
  input  gray2rgb_sel_e         sel_i,
  output logic [DATA_WIDTH-1:0] red_o,
  output logic [DATA_WIDTH-1:0] green_o,
  output logic [DATA_WIDTH-1:0] blue_o
);

  localparam logic [DATA_WIDTH-1:0] MAX = '1;

  logic [1:0]            seg;
  logic [DATA_WIDTH-1:0] f4;

  // Lower bits scaled x4 give the ramp position inside the current segment.
  assign seg = gray_i[DATA_WIDTH-1 -: 2];
  assign f4  = {gray_i[DATA_WIDTH-3:0], 2'b00};

  always_comb begin
    red_o   = gray_i;
    green_o = gray_i;
    blue_o  = gray_i;
    case (sel_i)
      GRAY2RGB_INV: begin
        red_o   = ~gray_i;
        green_o = ~gray_i;
        blue_o  = ~gray_i;
      end
      GRAY2RGB_HEAT: begin
        case (seg)
          HEAT_SEG_BLUE_CYAN: begin
            red_o   = '0;
            green_o = f4;
            blue_o  = MAX;
          end
          HEAT_SEG_CYAN_GREEN: begin
            red_o   = '0;
            green_o = MAX;
            blue_o  = MAX - f4;
          end
          HEAT_SEG_GREEN_YELLOW: begin
            red_o   = f4;
            green_o = MAX;
            blue_o  = '0;
          end
          default: begin
            red_o   = MAX;
            green_o = MAX - f4;
            blue_o  = '0;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tinyml_cam_gray2rgb_stream.sv
// rtl/tinyml_cam_gray2rgb_stream.sv - 2-stage gray-to-RGB stream expander with frame mode latch
module tinyml_cam_gray2rgb_stream
  import tinyml_cam_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 2,
  parameter int H_PIXELS   = 640
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [PPC*DATA_WIDTH-1:0]   s_gray,
  input  logic                        s_sof,
  input  logic                        s_eol,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [PPC*DATA_WIDTH-1:0]   m_red,
  output logic [PPC*DATA_WIDTH-1:0]   m_green,
  output logic [PPC*DATA_WIDTH-1:0]   m_blue,
  output logic                        m_sof,
  output logic                        m_eol,
  output logic                        line_err
);

  localparam int BW    = PPC * DATA_WIDTH;
  localparam int BEATS = H_PIXELS / PPC;
  localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS - 1);

  logic          v1_q, v1_d;
  logic [BW-1:0] gray1_q, gray1_d;
  logic          sof1_q, sof1_d;
  logic          eol1_q, eol1_d;
  gray2rgb_sel_e sel1_q, sel1_d;

  logic          v2_q, v2_d;
  logic [BW-1:0] red2_q, red2_d;
  logic [BW-1:0] green2_q, green2_d;
  logic [BW-1:0] blue2_q, blue2_d;
  logic          sof2_q, sof2_d;
  logic          eol2_q, eol2_d;

  logic [1:0]       mode_q, mode_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             line_err_q, line_err_d;

  logic             load2;
  logic             accept;
  gray2rgb_sel_e    sel_in;
  logic [COL_W-1:0] col_cur;
  logic             err_set;
  logic [BW-1:0]    red_c, green_c, blue_c;

  assign load2   = !v2_q || m_ready;
  assign s_ready = !v1_q || load2;
  assign accept  = s_valid && s_ready;

  // The SOF beat already uses the mode it latches.
  assign sel_in  = gray2rgb_decode(s_sof ? mode : mode_q);

  assign col_cur = s_sof ? '0 : col_q;
  assign err_set = s_eol ? (col_cur != COL_LAST) : (col_cur == COL_LAST);

  for (genvar i = 0; i < PPC; i++) begin : g_lane
    gray2rgb_1PPC #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .gray_i (gray1_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .sel_i  (sel1_q),
      .red_o  (red_c[i*DATA_WIDTH +: DATA_WIDTH]),
      .green_o(green_c[i*DATA_WIDTH +: DATA_WIDTH]),
      .blue_o (blue_c[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    v1_d       = v1_q;
    gray1_d    = gray1_q;
    sof1_d     = sof1_q;
    eol1_d     = eol1_q;
    sel1_d     = sel1_q;
    v2_d       = v2_q;
    red2_d     = red2_q;
    green2_d   = green2_q;
    blue2_d    = blue2_q;
    sof2_d     = sof2_q;
    eol2_d     = eol2_q;
    mode_d     = mode_q;
    col_d      = col_q;
    line_err_d = line_err_q;

    if (s_ready) begin
      v1_d = s_valid;
    end
    if (accept) begin
      gray1_d = s_gray;
      sof1_d  = s_sof;
      eol1_d  = s_eol;
      sel1_d  = sel_in;
      if (s_sof) begin
        mode_d = mode;
      end
      // SOF clears the sticky flag, but its own length check still applies.
      line_err_d = ((s_sof) ? 1'b0 : line_err_q) | err_set;
      col_d      = (s_eol || (col_cur == COL_LAST)) ? '0 : col_cur + COL_W'(1);
    end

    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        red2_d   = red_c;
        green2_d = green_c;
        blue2_d  = blue_c;
        sof2_d   = sof1_q;
        eol2_d   = eol1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      gray1_q    <= '0;
      sof1_q     <= 1'b0;
      eol1_q     <= 1'b0;
      sel1_q     <= GRAY2RGB_REPL;
      v2_q       <= 1'b0;
      red2_q     <= '0;
      green2_q   <= '0;
      blue2_q    <= '0;
      sof2_q     <= 1'b0;
      eol2_q     <= 1'b0;
      mode_q     <= 2'd0;
      col_q      <= '0;
      line_err_q <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      gray1_q    <= gray1_d;
      sof1_q     <= sof1_d;
      eol1_q     <= eol1_d;
      sel1_q     <= sel1_d;
      v2_q       <= v2_d;
      red2_q     <= red2_d;
      green2_q   <= green2_d;
      blue2_q    <= blue2_d;
      sof2_q     <= sof2_d;
      eol2_q     <= eol2_d;
      mode_q     <= mode_d;
      col_q      <= col_d;
      line_err_q <= line_err_d;
    end
  end

  assign m_valid  = v2_q;
  assign m_red    = red2_q;
  assign m_green  = green2_q;
  assign m_blue   = blue2_q;
  assign m_sof    = sof2_q;
  assign m_eol    = eol2_q;
  assign line_err = line_err_q;

endmodule

// File: tb/tb_tinyml_cam_gray2rgb_stream.sv
// tb/tb_tinyml_cam_gray2rgb_stream.sv - scoreboard bench for the gray-to-RGB stream expander
module tb_tinyml_cam_gray2rgb_stream;

  localparam int DW    = 8;
  localparam int PPC   = 2;
  localparam int HP    = 8;
  localparam int BW    = DW * PPC;
  localparam int BEATS = HP / PPC;
  localparam int MAXV  = (1 << DW) - 1;

  typedef struct packed {
    logic [BW-1:0] r;
    logic [BW-1:0] g;
    logic [BW-1:0] b;
    logic          sof;
    logic          eol;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_gray;
  logic          s_sof;
  logic          s_eol;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_red;
  logic [BW-1:0] m_green;
  logic [BW-1:0] m_blue;
  logic          m_sof;
  logic          m_eol;
  logic          line_err;

  tinyml_cam_gray2rgb_stream #(
    .DATA_WIDTH(DW),
    .PPC       (PPC),
    .H_PIXELS  (HP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_gray  (s_gray),
    .s_sof   (s_sof),
    .s_eol   (s_eol),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_red   (m_red),
    .m_green (m_green),
    .m_blue  (m_blue),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .line_err(line_err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  int   n_flushed = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   pop_cyc[$];

  int   cur_mode = 0;
  int   pos = 0;
  logic exp_err = 1'b0;

  bit   bp_en = 0;
  int   bp_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      m_ready = (bp_idx % 3 == 0);
      bp_idx++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [BW-1:0] r, input logic [BW-1:0] g,
                              input logic [BW-1:0] b, input logic sof, input logic eol);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.sof = sof; e.eol = eol;
    return e;
  endfunction

  // Reference colour mapping from the per-pixel rules, plain integer arithmetic.
  function automatic exp_t model(input logic [BW-1:0] gray, input int m,
                                 input logic sof, input logic eol);
    exp_t e;
    for (int l = 0; l < PPC; l++) begin
      int g, r, gr, b, f, seg;
      g  = int'(gray[l*DW +: DW]);
      r  = g; gr = g; b = g;
      if (m == 2) begin
        r = MAXV - g; gr = r; b = r;
      end else if (m == 1) begin
        seg = g / ((MAXV + 1) / 4);
        f   = (g % ((MAXV + 1) / 4)) * 4;
        case (seg)
          0:       begin r = 0;    gr = f;        b = MAXV;     end
          1:       begin r = 0;    gr = MAXV;     b = MAXV - f; end
          2:       begin r = f;    gr = MAXV;     b = 0;        end
          default: begin r = MAXV; gr = MAXV - f; b = 0;        end
        endcase
      end
      e.r[l*DW +: DW] = DW'(r);
      e.g[l*DW +: DW] = DW'(gr);
      e.b[l*DW +: DW] = DW'(b);
    end
    e.sof = sof;
    e.eol = eol;
    return e;
  endfunction

  function automatic void line_update(input logic sof, input logic eol);
    if (sof) begin
      pos = 0;
      exp_err = 1'b0;
    end
    if (eol) begin
      if (pos != BEATS - 1) exp_err = 1'b1;
      pos = 0;
    end else if (pos == BEATS - 1) begin
      exp_err = 1'b1;
      pos = 0;
    end else begin
      pos++;
    end
  endfunction

  function automatic void model_reset();
    cur_mode = 0;
    pos = 0;
    exp_err = 1'b0;
  endfunction

  // Monitor: every presented beat is compared with the scoreboard head, stalled or not.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got r=%h g=%h b=%h with empty scoreboard", m_red, m_green, m_blue);
      end else begin
        check(m_ready ? "beat" : "stall_hold",
              64'({m_red, m_green, m_blue, m_sof, m_eol}),
              64'({exp_q[0].r, exp_q[0].g, exp_q[0].b, exp_q[0].sof, exp_q[0].eol}));
        if (m_ready) begin
          void'(exp_q.pop_front());
          n_popped++;
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] gray, input logic sof, input logic eol,
                           input logic [1:0] md, input bit use_exp, input exp_t want);
    int   guard;
    exp_t e;
    s_valid = 1'b1;
    s_gray  = gray;
    s_sof   = sof;
    s_eol   = eol;
    mode    = md;
    guard   = 0;
    @(negedge clk);
    while (!s_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: s_ready=%b want 1", s_ready);
    end else begin
      if (sof) cur_mode = int'(md);
      e = use_exp ? want : model(gray, cur_mode, sof, eol);
      exp_q.push_back(e);
      n_pushed++;
      line_update(sof, eol);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("line_err", 64'(line_err), 64'(exp_err));
  endtask

  task automatic send_rand(input logic sof, input logic eol, input logic [1:0] md);
    send_beat(BW'($urandom), sof, eol, md, 1'b0, '0);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] md;
    logic       eol;
    int         c0;
    rst_n   = 1'b0;
    mode    = 2'd0;
    s_valid = 1'b0;
    s_gray  = '0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_s_ready", 64'(s_ready), 64'd1);
    check("reset_line_err", 64'(line_err), 64'd0);
    @(posedge clk);
    #1;

    // Replicate
    send_beat(16'h5A10, 1'b1, 1'b0, 2'd0, 1'b1, mk(16'h5A10, 16'h5A10, 16'h5A10, 1'b1, 1'b0));
    wait_drain();

    // Heatmap segment corners
    send_beat(16'h9040, 1'b1, 1'b0, 2'd1, 1'b1, mk(16'h4000, 16'hFFFF, 16'h00FF, 1'b1, 1'b0));
    send_beat(16'hFF00, 1'b0, 1'b0, 2'd1, 1'b1, mk(16'hFF00, 16'h0300, 16'h00FF, 1'b0, 1'b0));
    wait_drain();

    // Invert, mid-frame mode change ignored until next SOF
    send_beat(16'h5A5A, 1'b1, 1'b0, 2'd2, 1'b1, mk(16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 1'b0));
    send_beat(16'h0F5A, 1'b0, 1'b0, 2'd0, 1'b1, mk(16'hF0A5, 16'hF0A5, 16'hF0A5, 1'b0, 1'b0));
    send_beat(16'h0F5A, 1'b1, 1'b0, 2'd0, 1'b1, mk(16'h0F5A, 16'h0F5A, 16'h0F5A, 1'b1, 1'b0));
    wait_drain();

    // Full rate with m_ready held high
    md = 2'($urandom_range(0, 3));
    pop_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send_rand(i == 0, (i % BEATS) == BEATS - 1, 2'($urandom_range(0, 3)) | ((i == 0) ? md : 2'd0));
    end
    check("input_rate_cycles", 64'(cyc - c0), 64'd8);
    wait_drain();
    check("output_beats", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) check("output_rate_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // Backpressure 1,0,0 pattern with random data, modes and occasional bad EOL
    bp_idx = 0;
    bp_en  = 1;
    for (int i = 0; i < 16; i++) begin
      eol = ((i % BEATS) == BEATS - 1);
      if ($urandom_range(0, 7) == 0) eol = ~eol;
      send_rand(i == 0 || i == 8, eol, 2'($urandom_range(0, 3)));
    end
    wait_drain();
    bp_en = 0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    @(posedge clk);
    #1;

    // Line checker: short line, sticky, cleared by SOF, overlong line
    send_rand(1'b1, 1'b0, 2'd2);
    send_rand(1'b0, 1'b0, 2'd0);
    send_rand(1'b0, 1'b1, 2'd0);
    send_rand(1'b0, 1'b0, 2'd0);
    send_rand(1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 4; i++) send_rand(1'b0, 1'b0, 2'd1);
    wait_drain();
    check("line_err_sticky", 64'(line_err), 64'd1);

    // Reset with two beats in flight
    m_ready = 1'b0;
    send_rand(1'b0, 1'b0, 2'd1);
    send_rand(1'b0, 1'b0, 2'd1);
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_line_err", 64'(line_err), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    n_flushed += exp_q.size();
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    send_beat(16'h9040, 1'b0, 1'b0, 2'd2, 1'b1, mk(16'h9040, 16'h9040, 16'h9040, 1'b0, 1'b0));
    send_beat(16'h9040, 1'b1, 1'b0, 2'd1, 1'b1, mk(16'h4000, 16'hFFFF, 16'h00FF, 1'b1, 1'b0));
    send_rand(1'b0, 1'b0, 2'd0);
    send_rand(1'b0, 1'b0, 2'd0);
    send_rand(1'b0, 1'b1, 2'd0);
    wait_drain();

    check("beat_conservation", 64'(n_pushed), 64'(n_popped + n_flushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
